// File: rtl/interrupt_sequencer.sv
// Arbitrates RESET/NMI/IRQ/BRK at opcode boundaries and sequences the 7-step entry; outputs registered, ready=0 freezes all state.
// Optional INT_SYNC_EN: 2-flop synchronizers on nmi_in/irq_in (adds 2 cycles of request latency).
module interrupt_sequencer #(
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] RST_VEC = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic        sync,
    input  logic        nmi_in,
    input  logic        irq_in,
    input  logic        i_flag,
    input  logic        brk_req,
    output logic        busy,
    output logic [2:0]  step,
    output logic [2:0]  bus_op,
    output logic        rnw,
    output logic [15:0] vector_addr,
    output logic        b_flag,
    output logic        set_i,
    output logic        done
);

    typedef enum logic [1:0] {K_RESET, K_NMI, K_IRQ, K_BRK} kind_t;
    typedef enum logic {IDLE, ENTRY} state_t;

    state_t      state, nxt_state;
    kind_t       kind, nxt_kind;
    logic [2:0]  nxt_step;
    logic [15:0] nxt_vec;
    logic        nmi_s, irq_s;
    logic        nmi_prev, nmi_pend, pending_reset;
    logic        nmi_edge, consume, clr_reset, nxt_entry;

`ifdef INT_SYNC_EN
    logic [1:0] nmi_sync, irq_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_sync <= 2'b00;
            irq_sync <= 2'b00;
        end else begin
            nmi_sync <= {nmi_sync[0], nmi_in};
            irq_sync <= {irq_sync[0], irq_in};
        end
    end

    assign nmi_s = nmi_sync[1];
    assign irq_s = irq_sync[1];
`else
    assign nmi_s = nmi_in;
    assign irq_s = irq_in;
`endif

    assign nmi_edge = nmi_s & ~nmi_prev;

    function automatic logic [2:0] op_of(input logic [2:0] s);
        return (s < 3'd2) ? 3'd1 : s;
    endfunction

    always_comb begin
        nxt_state = state;
        nxt_kind  = kind;
        nxt_step  = step;
        nxt_vec   = vector_addr;
        consume   = 1'b0;
        clr_reset = 1'b0;
        if (ready) begin
            case (state)
                IDLE: begin
                    if (pending_reset) begin
                        nxt_state = ENTRY;
                        nxt_kind  = K_RESET;
                        nxt_step  = 3'd0;
                        nxt_vec   = RST_VEC;
                    end else if (sync) begin
                        if (nmi_pend) begin
                            nxt_state = ENTRY;
                            nxt_kind  = K_NMI;
                            nxt_step  = 3'd0;
                            nxt_vec   = NMI_VEC;
                        end else if (irq_s && !i_flag) begin
                            nxt_state = ENTRY;
                            nxt_kind  = K_IRQ;
                            nxt_step  = 3'd0;
                            nxt_vec   = IRQ_VEC;
                        end else if (brk_req) begin
                            nxt_state = ENTRY;
                            nxt_kind  = K_BRK;
                            nxt_step  = 3'd0;
                            nxt_vec   = IRQ_VEC;
                        end
                    end
                end
                ENTRY: begin
                    if (step == 3'd6) begin
                        nxt_state = IDLE;
                        nxt_step  = 3'd0;
                        clr_reset = (kind == K_RESET);
                    end else begin
                        nxt_step = step + 3'd1;
                        // An NMI pending by the PUSH_P step takes over the vector fetch of IRQ/BRK.
                        if (step == 3'd4 && nmi_pend && kind != K_RESET) begin
                            consume = 1'b1;
                            nxt_vec = NMI_VEC;
                        end
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    assign nxt_entry = (nxt_state == ENTRY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            kind          <= K_RESET;
            busy          <= 1'b0;
            step          <= 3'd0;
            bus_op        <= 3'd0;
            rnw           <= 1'b1;
            vector_addr   <= RST_VEC;
            b_flag        <= 1'b0;
            set_i         <= 1'b0;
            done          <= 1'b0;
            nmi_prev      <= 1'b0;
            nmi_pend      <= 1'b0;
            pending_reset <= 1'b1;
        end else begin
            state         <= nxt_state;
            kind          <= nxt_kind;
            busy          <= nxt_entry;
            step          <= nxt_step;
            bus_op        <= nxt_entry ? op_of(nxt_step) : 3'd0;
            rnw           <= !(nxt_entry && nxt_kind != K_RESET &&
                               nxt_step >= 3'd2 && nxt_step <= 3'd4);
            vector_addr   <= nxt_vec;
            b_flag        <= nxt_entry && nxt_step == 3'd4 && nxt_kind == K_BRK;
            set_i         <= nxt_entry && nxt_step == 3'd5;
            done          <= nxt_entry && nxt_step == 3'd6;
            nmi_prev      <= nmi_s;
            nmi_pend      <= (nmi_pend & ~consume) | nmi_edge;
            pending_reset <= pending_reset & ~clr_reset;
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: reset entry, IRQ/BRK/NMI entries, hijack, stall and async reset abort.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst, ready, sync, nmi_in, irq_in, i_flag, brk_req;
    logic        busy, rnw, b_flag, set_i, done;
    logic [2:0]  step, bus_op;
    logic [15:0] vector_addr;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_ops [7] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

    interrupt_sequencer dut (
        .clk(clk), .rst(rst), .ready(ready), .sync(sync),
        .nmi_in(nmi_in), .irq_in(irq_in), .i_flag(i_flag), .brk_req(brk_req),
        .busy(busy), .step(step), .bus_op(bus_op), .rnw(rnw),
        .vector_addr(vector_addr), .b_flag(b_flag), .set_i(set_i), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 16'd0);
        check({tag, "_step"}, step, 16'd0);
        check({tag, "_op"}, bus_op, 16'd0);
        check({tag, "_rnw"}, rnw, 16'd1);
        check({tag, "_vec"}, vector_addr, 16'hFFFC);
        check({tag, "_bflag"}, b_flag, 16'd0);
        check({tag, "_seti"}, set_i, 16'd0);
        check({tag, "_done"}, done, 16'd0);
    endtask

    // Called right after rst is released; walks the full RESET entry and back to idle.
    task automatic walk_reset();
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("rst_op%0d", k), bus_op, exp_ops[k]);
            check($sformatf("rst_step%0d", k), step, k[2:0]);
            check($sformatf("rst_rnw%0d", k), rnw, 16'd1);
            check($sformatf("rst_vec%0d", k), vector_addr, 16'hFFFC);
            check($sformatf("rst_seti%0d", k), set_i, (k == 5) ? 16'd1 : 16'd0);
            check($sformatf("rst_done%0d", k), done, (k == 6) ? 16'd1 : 16'd0);
        end
        tick();
        check("rst_back_idle", busy, 16'd0);
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; sync = 1'b0; nmi_in = 1'b0;
        irq_in = 1'b0; i_flag = 1'b0; brk_req = 1'b0;
        tick();
        tick();
        check_reset_values("por");

        rst = 1'b0;
        walk_reset();

        // IRQ with interrupts enabled
        irq_in = 1'b1; sync = 1'b1;
        tick();
        check("irq_busy", busy, 16'd1);
        check("irq_op0", bus_op, 16'd1);
        irq_in = 1'b0; sync = 1'b0;
        repeat (4) tick();
        check("irq_s4_op", bus_op, 16'd4);
        check("irq_s4_rnw", rnw, 16'd0);
        check("irq_s4_bflag", b_flag, 16'd0);
        check("irq_s4_vec", vector_addr, 16'hFFFE);
        repeat (3) tick();
        check("irq_idle", busy, 16'd0);

        // IRQ masked
        irq_in = 1'b1; i_flag = 1'b1; sync = 1'b1;
        tick();
        check("irq_masked", busy, 16'd0);
        irq_in = 1'b0; i_flag = 1'b0; sync = 1'b0;
        tick();

        // BRK, hijacked by NMI rising at step 2
        brk_req = 1'b1; sync = 1'b1;
        tick();
        check("brk_busy", busy, 16'd1);
        brk_req = 1'b0; sync = 1'b0;
        repeat (2) tick();
        check("brk_s2", step, 16'd2);
        nmi_in = 1'b1;
        repeat (2) tick();
        check("brk_s4_bflag", b_flag, 16'd1);
        check("brk_s4_vec", vector_addr, 16'hFFFE);
        tick();
        check("hijack_vec", vector_addr, 16'hFFFA);
        check("hijack_seti", set_i, 16'd1);
        tick();
        check("hijack_done", done, 16'd1);
        check("hijack_s6_vec", vector_addr, 16'hFFFA);
        tick();
        check("hijack_idle", busy, 16'd0);
        sync = 1'b1;
        tick();
        check("hijack_consumed", busy, 16'd0);
        nmi_in = 1'b0; sync = 1'b0;
        tick();

        // NMI rising at step 6 of an IRQ entry, held high afterwards
        irq_in = 1'b1; sync = 1'b1;
        tick();
        irq_in = 1'b0; sync = 1'b0;
        repeat (6) tick();
        check("irq2_s6_done", done, 16'd1);
        check("irq2_s6_vec", vector_addr, 16'hFFFE);
        nmi_in = 1'b1;
        tick();
        check("irq2_idle", busy, 16'd0);
        sync = 1'b1;
        tick();
        check("nmi_busy", busy, 16'd1);
        check("nmi_vec", vector_addr, 16'hFFFA);
        sync = 1'b0;
        repeat (4) tick();
        check("nmi_s4_rnw", rnw, 16'd0);
        check("nmi_s4_bflag", b_flag, 16'd0);
        tick();
        check("nmi_s5_seti", set_i, 16'd1);
        repeat (2) tick();
        check("nmi_idle", busy, 16'd0);
        sync = 1'b1;
        tick();
        check("nmi_level_no_retrigger", busy, 16'd0);
        sync = 1'b1;
        tick();
        check("nmi_level_no_retrigger2", busy, 16'd0);
        nmi_in = 1'b0; sync = 1'b0;
        tick();

        // Stall at step 3
        irq_in = 1'b1; sync = 1'b1;
        tick();
        irq_in = 1'b0; sync = 1'b0;
        repeat (3) tick();
        check("stall_pre_step", step, 16'd3);
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall_step%0d", k), step, 16'd3);
            check($sformatf("stall_op%0d", k), bus_op, 16'd3);
            check($sformatf("stall_rnw%0d", k), rnw, 16'd0);
        end
        ready = 1'b1;
        tick();
        check("stall_resume_step", step, 16'd4);
        check("stall_resume_op", bus_op, 16'd4);
        repeat (3) tick();
        check("stall_idle", busy, 16'd0);

        // Async reset in the middle of an NMI entry
        nmi_in = 1'b1;
        tick();
        sync = 1'b1;
        tick();
        check("nmi2_busy", busy, 16'd1);
        sync = 1'b0;
        repeat (4) tick();
        check("nmi2_s4", bus_op, 16'd4);
        #2 rst = 1'b1;
        #1;
        check_reset_values("abort");
        nmi_in = 1'b0;
        tick();
        rst = 1'b0;
        walk_reset();
        sync = 1'b1;
        tick();
        check("nmi_cleared_by_rst", busy, 16'd0);
        sync = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Schedules the 8227 core's non-instruction control flow: arbitrates RESET, NMI, IRQ and BRK at instruction boundaries.
- Runs the 7-cycle entry sequence that pushes PCH, PCL and P, then fetches the handler vector.
- Sits beside the instruction decoder and drives the stack and bus-control micro-ops into the datapath.
- The datapath performs the actual bus transfers; this block only sequences them.

Parameters:
NMI_VEC, 16'hFFFA, address of NMI vector low byte
RST_VEC, 16'hFFFC, address of RESET vector low byte
IRQ_VEC, 16'hFFFE, address of IRQ/BRK vector low byte

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ready  in  1  1=advance, 0=stall sequencer in place
sync  in  1  core at opcode-fetch boundary this cycle
nmi_in  in  1  NMI request, rising-edge sensitive
irq_in  in  1  IRQ request, level sensitive
i_flag  in  1  P.I interrupt-disable flag
brk_req  in  1  decoder pulse: BRK opcode fetched
busy  out  1  entry sequence in progress
step  out  3  current entry step 0..6
bus_op  out  3  0 NONE, 1 DUMMY_RD, 2 PUSH_PCH, 3 PUSH_PCL, 4 PUSH_P, 5 VEC_LO, 6 VEC_HI
rnw  out  1  1=read; forced 1 on all steps of a RESET entry
vector_addr  out  16  address for VEC_LO; VEC_HI uses vector_addr+1
b_flag  out  1  B bit for PUSH_P: 1 only for BRK
set_i  out  1  one-cycle pulse: set P.I
done  out  1  one-cycle pulse: vector fetched, core resumes fetch

Behaviour:
- Reset values while rst=1:
  - busy=0, step=0, bus_op=0, rnw=1, vector_addr=RST_VEC, b_flag=0, set_i=0, done=0.
  - NMI edge latch cleared; pending_reset=1.
- States:
  - IDLE: busy=0, bus_op=NONE.
  - ENTRY: busy=1; step 0..6 mapped to bus_op 1,1,2,3,4,5,6.
- IDLE->ENTRY:
  - pending_reset: enter on the first ready clock after rst falls; sync not required.
  - Otherwise enter on the clock where sync=1 and ready=1.
  - Priority: pending_reset > nmi_pend > (irq_in & ~i_flag) > brk_req.
  - kind is latched on entry; step=0.
- ENTRY advance:
  - step increments on each clock with ready=1; held when ready=0.
  - All outputs remain stable during a stall.
- Step 4 (PUSH_P): b_flag = (kind==BRK); rnw=0 unless kind==RESET.
- Step 5 (VEC_LO): set_i=1 for one cycle.
- Step 6 (VEC_HI): done=1; next ready clock returns to IDLE, step=0. pending_reset is cleared there if kind was RESET.
- NMI edge detect:
  - nmi_pend sets on a 0->1 transition of nmi_in, sampled per clock.
  - It stays set until consumed; a held-high level does not re-trigger.
- NMI hijack:
  - Applies if nmi_pend is set while kind is IRQ or BRK and step<=4.
  - vector_addr switches to NMI_VEC at step 5, and nmi_pend is consumed there.
  - b_flag already pushed is unchanged.
  - An NMI after step 4 stays pending and is taken at the next boundary.
- Consumption: NMI is consumed at step 5 of an NMI (or hijacked) entry. IRQ is level sensitive and not latched; if irq_in drops before the boundary, it is not taken.
- Simultaneous brk_req and IRQ at a boundary: IRQ wins (b_flag=0). BRK is re-detected after the RTI.
- vector_addr by kind:
  - RST_VEC for RESET.
  - NMI_VEC for NMI.
  - IRQ_VEC for IRQ and BRK.
- rst asserted mid-entry: immediate abort to reset values; a fresh RESET entry follows release.

Optional Feature:
INT_SYNC_EN
- Defined: nmi_in and irq_in each pass through a 2-flop synchronizer before edge detect and arbitration. This adds 2 cycles of request latency; synchronizer flops reset to 0.
- Undefined: inputs are used directly, with 0 added latency. Edge detect uses a single previous-value flop.

Test Plan:
- Release rst -> next 7 ready clocks give bus_op 1,1,2,3,4,5,6:
  - rnw=1 on every step; vector_addr=16'hFFFC.
  - set_i pulses at step 5; done at step 6.
- irq_in=1 with i_flag=0 and sync=1 -> entry begins:
  - step 4 has rnw=0, b_flag=0; vector_addr=16'hFFFE.
  - Repeat with i_flag=1 -> busy stays 0.
- brk_req=1 with sync=1 -> step 4 has b_flag=1 and vector_addr=16'hFFFE.
  - nmi_in rises at step 2 -> vector_addr=16'hFFFA at step 5; nmi_pend clear afterward.
- nmi_in rises at step 6 of an IRQ entry and is held high -> exactly one NMI entry at the next sync. No second entry while the level is held.
- ready=0 for 3 clocks at step 3 -> step=3 and bus_op=PUSH_PCL held for 3 clocks; step 4 follows the first ready clock.
- rst pulse at step 4 of an NMI entry -> outputs return to reset values asynchronously; after release, the RESET sequence runs with vector_addr=16'hFFFC.
